// File: rtl/cog_loader.sv
// -----------------------------------------------------------------------------
// cog_loader
//
// Boot-copy sequencer for a cog. On start it reads LOAD_LONGS consecutive longs
// from hub RAM beginning at ptr and writes them into cog RAM addresses
// 0..LOAD_LONGS-1. Then it pulses done so the cog may begin execution.
//
// Optional feature (compile-time macro COG_LOAD_ZERO_FILL_EN):
//   When defined, addresses LOAD_LONGS..511 are cleared to zero after the copy.
//   This adds 512-LOAD_LONGS cycles before done. When undefined, those
//   addresses are never written.
//
// Parameters:
//   LOAD_LONGS  number of longs copied (1..512)
//   HUB_AW      width of the hub long address
//
// Ports:
//   clk       in   single clock
//   nres      in   asynchronous active-low reset
//   start     in   one-cycle load request; also restarts a load in progress
//   ptr       in   hub long address of the first long, sampled with start
//   busy      out  high from the cycle after start until done
//   done      out  one-cycle completion pulse
//   hub_req   out  hub read request
//   hub_addr  out  hub long address, held while waiting for hub_ack
//   hub_ack   in   hub grant; hub_q is valid in the same cycle
//   hub_q     in   hub read data
//   ram_ena   out  cog RAM enable (write-only usage)
//   ram_w     out  cog RAM write strobe
//   ram_a     out  cog RAM address
//   ram_d     out  cog RAM write data
// -----------------------------------------------------------------------------
module cog_loader #(
    parameter int LOAD_LONGS = 496,
    parameter int HUB_AW     = 14
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              start,
    input  logic [HUB_AW-1:0] ptr,
    output logic              busy,
    output logic              done,
    output logic              hub_req,
    output logic [HUB_AW-1:0] hub_addr,
    input  logic              hub_ack,
    input  logic [31:0]       hub_q,
    output logic              ram_ena,
    output logic              ram_w,
    output logic [8:0]        ram_a,
    output logic [31:0]       ram_d
);

    localparam logic [9:0]        LOAD_CNT = 10'(LOAD_LONGS);
    localparam logic [HUB_AW-1:0] HUB_ONE  = {{(HUB_AW-1){1'b0}}, 1'b1};

`ifdef COG_LOAD_ZERO_FILL_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FILL  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FIN   = 2'd3
    } state_t;
`endif

    state_t              r_state, w_state_next;
    logic                r_busy, w_busy_next;
    logic                r_done, w_done_next;
    logic                r_hub_req, w_hub_req_next;
    logic [HUB_AW-1:0]   r_hub_addr, w_hub_addr_next;
    logic [9:0]          r_idx, w_idx_next;
    // Capture stage: an acked long sits here for one cycle before it is
    // presented to the RAM port. This lets acks arrive back-to-back without
    // overwriting data that is still being written.
    logic                r_cap_vld, w_cap_vld_next;
    logic [8:0]          r_cap_a, w_cap_a_next;
    logic [31:0]         r_cap_d, w_cap_d_next;
    logic                r_ram_ena, w_ram_ena_next;
    logic                r_ram_w, w_ram_w_next;
    logic [8:0]          r_ram_a, w_ram_a_next;
    logic [31:0]         r_ram_d, w_ram_d_next;
`ifdef COG_LOAD_ZERO_FILL_EN
    logic [8:0]          r_fill_a, w_fill_a_next;
`endif

    // hub_req is only ever high in FETCH, so this alone qualifies the ack.
    logic w_ack;
    assign w_ack = r_hub_req & hub_ack;

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hub_req  <= 1'b0;
            r_hub_addr <= '0;
            r_idx      <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_a    <= '0;
            r_cap_d    <= '0;
            r_ram_ena  <= 1'b0;
            r_ram_w    <= 1'b0;
            r_ram_a    <= '0;
            r_ram_d    <= '0;
`ifdef COG_LOAD_ZERO_FILL_EN
            r_fill_a   <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_hub_req  <= w_hub_req_next;
            r_hub_addr <= w_hub_addr_next;
            r_idx      <= w_idx_next;
            r_cap_vld  <= w_cap_vld_next;
            r_cap_a    <= w_cap_a_next;
            r_cap_d    <= w_cap_d_next;
            r_ram_ena  <= w_ram_ena_next;
            r_ram_w    <= w_ram_w_next;
            r_ram_a    <= w_ram_a_next;
            r_ram_d    <= w_ram_d_next;
`ifdef COG_LOAD_ZERO_FILL_EN
            r_fill_a   <= w_fill_a_next;
`endif
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_hub_req_next  = r_hub_req;
        w_hub_addr_next = r_hub_addr;
        w_idx_next      = r_idx;
        w_cap_vld_next  = 1'b0;
        w_cap_a_next    = r_cap_a;
        w_cap_d_next    = r_cap_d;
        w_ram_ena_next  = 1'b0;
        w_ram_w_next    = 1'b0;
        w_ram_a_next    = r_ram_a;
        w_ram_d_next    = r_ram_d;
`ifdef COG_LOAD_ZERO_FILL_EN
        w_fill_a_next   = r_fill_a;
`endif

        // A captured long always reaches the RAM, even across a restart.
        if (r_cap_vld) begin
            w_ram_ena_next = 1'b1;
            w_ram_w_next   = 1'b1;
            w_ram_a_next   = r_cap_a;
            w_ram_d_next   = r_cap_d;
        end

        if (start) begin
            // Fresh start or restart: any ack this cycle is dropped.
            w_state_next    = ST_FETCH;
            w_busy_next     = 1'b1;
            w_hub_req_next  = 1'b1;
            w_hub_addr_next = ptr;
            w_idx_next      = '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end

                ST_FETCH: begin
                    if (w_ack) begin
                        w_cap_vld_next  = 1'b1;
                        w_cap_a_next    = r_idx[8:0];
                        w_cap_d_next    = hub_q;
                        w_idx_next      = r_idx + 10'd1;
                        w_hub_addr_next = r_hub_addr + HUB_ONE;
                        if (r_idx + 10'd1 == LOAD_CNT) begin
                            w_hub_req_next = 1'b0;
                        end
                    end else if (r_idx == LOAD_CNT && r_cap_vld) begin
                        // The last long moves to the RAM port this edge.
`ifdef COG_LOAD_ZERO_FILL_EN
                        if (LOAD_LONGS < 512) begin
                            w_state_next  = ST_FILL;
                            w_fill_a_next = LOAD_CNT[8:0];
                        end else begin
                            w_state_next  = ST_FIN;
                        end
`else
                        w_state_next = ST_FIN;
`endif
                    end
                end

`ifdef COG_LOAD_ZERO_FILL_EN
                ST_FILL: begin
                    w_ram_ena_next = 1'b1;
                    w_ram_w_next   = 1'b1;
                    w_ram_a_next   = r_fill_a;
                    w_ram_d_next   = 32'h0;
                    w_fill_a_next  = r_fill_a + 9'd1;
                    if (r_fill_a == 9'd511) begin
                        w_state_next = ST_FIN;
                    end
                end
`endif

                ST_FIN: begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = ST_IDLE;
                end

                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hub_req  = r_hub_req;
    assign hub_addr = r_hub_addr;
    assign ram_ena  = r_ram_ena;
    assign ram_w    = r_ram_w;
    assign ram_a    = r_ram_a;
    assign ram_d    = r_ram_d;

endmodule
